// File: rtl/washmach_ctrl.sv
// washmach_ctrl: wash-cycle sequencer driving the shared timer through
// prewash (optional), wash, N rinses, spin and an end-of-cycle alarm.
// Each phase is preceded by a one-cycle GAP that restarts the timer.
// Optional feature: define WASHMACH_CTRL_PREWASH_EN to add a PREWASH phase
// at the start of programs 00 and 01 and make phase_led[0] live.
module washmach_ctrl #(
  parameter int WASH_TIME    = 5,
  parameter int RINSE_TIME   = 3,
  parameter int RINSE_REPEAT = 2,
  parameter int SPIN_TIME    = 2,
  parameter int PREWASH_TIME = 4,
  parameter int ALARM_TIME   = 3
) (
  input  logic        clk_src,
  input  logic        rst_n,
  input  logic        switch_power,
  input  logic        switch_en,
  input  logic [1:0]  mode,
  input  logic        count_end_flag,
  output logic [31:0] sum_count,
  output logic        count_start_flag,
  output logic [3:0]  phase_led,
  output logic        alarm,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE,
    GAP,
    PREWASH,
    WASH,
    RINSE,
    SPIN,
    ALARM
  } state_t;

  state_t     state;
  state_t     next_phase;
  logic [2:0] rinse_cnt;
  logic [1:0] mode_q;
  logic       en_prev;
  logic       armed;

  // Phase length handed to the timer. PREWASH is unreachable unless the
  // prewash option is built in, so its entry drops out of the default build.
  function automatic logic [31:0] phase_time(input state_t p);
    logic [31:0] t;
    t = 32'd0;
    case (p)
      PREWASH: t = 32'(PREWASH_TIME);
      WASH:    t = 32'(WASH_TIME);
      RINSE:   t = 32'(RINSE_TIME);
      SPIN:    t = 32'(SPIN_TIME);
      ALARM:   t = 32'(ALARM_TIME);
      default: t = 32'd0;
    endcase
    return t;
  endfunction

  // One-hot {spin, rinse, wash, prewash}; ALARM and IDLE light nothing.
  function automatic logic [3:0] phase_leds(input state_t p);
    logic [3:0] l;
    l = 4'b0000;
    case (p)
`ifdef WASHMACH_CTRL_PREWASH_EN
      PREWASH: l = 4'b0001;
`else
      PREWASH: l = 4'b0000;
`endif
      WASH:    l = 4'b0010;
      RINSE:   l = 4'b0100;
      SPIN:    l = 4'b1000;
      default: l = 4'b0000;
    endcase
    return l;
  endfunction

  // First phase of each program.
  function automatic state_t first_phase(input logic [1:0] m);
    state_t f;
    case (m)
`ifdef WASHMACH_CTRL_PREWASH_EN
      2'b00, 2'b01: f = PREWASH;
`else
      2'b00, 2'b01: f = WASH;
`endif
      2'b10:        f = RINSE;
      default:      f = SPIN;
    endcase
    return f;
  endfunction

  // Successor of a phase; 'last' says the rinse just finished was the final one.
  function automatic state_t phase_succ(input state_t p, input logic [1:0] m,
                                        input logic last);
    state_t s;
    case (p)
      PREWASH: s = WASH;
      WASH:    s = (m == 2'b11) ? ALARM : RINSE;
      RINSE:   s = !last ? RINSE : ((m == 2'b01) ? ALARM : SPIN);
      SPIN:    s = ALARM;
      default: s = IDLE;
    endcase
    return s;
  endfunction

  function automatic logic last_rinse(input logic [2:0] c);
    return (({1'b0, c} + 4'd1) == 4'(RINSE_REPEAT));
  endfunction

  // Sequencer: start detection, GAP/phase stepping, pause, power-off and
  // registered outputs all update together so no input reaches an output
  // combinationally.
  always_ff @(posedge clk_src or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      next_phase       <= IDLE;
      rinse_cnt        <= 3'd0;
      mode_q           <= 2'b00;
      en_prev          <= 1'b1;
      armed            <= 1'b0;
      sum_count        <= 32'd0;
      count_start_flag <= 1'b0;
      phase_led        <= 4'b0000;
      alarm            <= 1'b0;
      busy             <= 1'b0;
    end else begin
      en_prev <= switch_en;
      if (!switch_power) begin
        state            <= IDLE;
        next_phase       <= IDLE;
        rinse_cnt        <= 3'd0;
        armed            <= 1'b0;
        sum_count        <= 32'd0;
        count_start_flag <= 1'b0;
        phase_led        <= 4'b0000;
        alarm            <= 1'b0;
        busy             <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (switch_en && !en_prev) begin
              mode_q           <= mode;
              rinse_cnt        <= 3'd0;
              next_phase       <= first_phase(mode);
              state            <= GAP;
              busy             <= 1'b1;
              count_start_flag <= 1'b0;
              phase_led        <= phase_leds(first_phase(mode));
            end
          end
          GAP: begin
            if (phase_time(next_phase) == 32'd0) begin
              if (phase_succ(next_phase, mode_q, 1'b1) == IDLE) begin
                state     <= IDLE;
                busy      <= 1'b0;
                sum_count <= 32'd0;
                phase_led <= 4'b0000;
                alarm     <= 1'b0;
              end else begin
                next_phase <= phase_succ(next_phase, mode_q, 1'b1);
                phase_led  <= phase_leds(phase_succ(next_phase, mode_q, 1'b1));
              end
            end else begin
              state            <= next_phase;
              sum_count        <= phase_time(next_phase);
              count_start_flag <= 1'b1;
              armed            <= 1'b0;
              alarm            <= (next_phase == ALARM);
              phase_led        <= phase_leds(next_phase);
            end
          end
          PREWASH, WASH, RINSE, SPIN, ALARM: begin
            armed <= 1'b1;
            if (switch_en && armed && count_end_flag) begin
              if (state == ALARM) begin
                state            <= IDLE;
                next_phase       <= IDLE;
                busy             <= 1'b0;
                count_start_flag <= 1'b0;
                sum_count        <= 32'd0;
                phase_led        <= 4'b0000;
                alarm            <= 1'b0;
              end else begin
                state            <= GAP;
                count_start_flag <= 1'b0;
                next_phase       <= phase_succ(state, mode_q, last_rinse(rinse_cnt));
                phase_led        <= phase_leds(phase_succ(state, mode_q,
                                                          last_rinse(rinse_cnt)));
                if ((state == RINSE) && !last_rinse(rinse_cnt)) begin
                  rinse_cnt <= rinse_cnt + 3'd1;
                end
              end
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_washmach_ctrl.sv
// tb_washmach_ctrl: self-checking bench for washmach_ctrl. A phase-list model
// built from the program rules predicts each phase's timer load, LED and alarm;
// a small timer model answers count_start_flag with count_end_flag.
module tb_washmach_ctrl;

  localparam int WASH_T  = 5;
  localparam int RINSE_T = 3;
  localparam int RINSE_N = 2;
  localparam int SPIN_T  = 2;
  localparam int PRE_T   = 4;
  localparam int ALARM_T = 3;

  logic        clk_src;
  logic        rst_n;
  logic        switch_power;
  logic        switch_en;
  logic [1:0]  mode;
  logic        count_end_flag;
  logic [31:0] sum_count;
  logic        count_start_flag;
  logic [3:0]  phase_led;
  logic        alarm;
  logic        busy;

  int checks = 0;
  int errors = 0;

  int         exp_time[$];
  logic [3:0] exp_led[$];
  bit         exp_alarm[$];

  washmach_ctrl #(
    .WASH_TIME   (WASH_T),
    .RINSE_TIME  (RINSE_T),
    .RINSE_REPEAT(RINSE_N),
    .SPIN_TIME   (SPIN_T),
    .PREWASH_TIME(PRE_T),
    .ALARM_TIME  (ALARM_T)
  ) dut (
    .clk_src         (clk_src),
    .rst_n           (rst_n),
    .switch_power    (switch_power),
    .switch_en       (switch_en),
    .mode            (mode),
    .count_end_flag  (count_end_flag),
    .sum_count       (sum_count),
    .count_start_flag(count_start_flag),
    .phase_led       (phase_led),
    .alarm           (alarm),
    .busy            (busy)
  );

  // Free-running 10-unit clock.
  initial clk_src = 1'b0;
  always #5 clk_src = ~clk_src;

  // Inputs are driven and outputs sampled 1 unit after each rising edge.
  task automatic step();
    @(posedge clk_src);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] got,
                              input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag, input bit with_sum);
    check_output({tag, ".busy"}, 32'(busy), 32'd0);
    check_output({tag, ".start"}, 32'(count_start_flag), 32'd0);
    check_output({tag, ".led"}, 32'(phase_led), 32'd0);
    check_output({tag, ".alarm"}, 32'(alarm), 32'd0);
    if (with_sum) check_output({tag, ".sum"}, sum_count, 32'd0);
  endtask

  // Program as a list of phases: which phases each mode contains, in order.
  function automatic void build_program(input logic [1:0] m);
    exp_time.delete();
    exp_led.delete();
    exp_alarm.delete();
`ifdef WASHMACH_CTRL_PREWASH_EN
    if (m inside {2'b00, 2'b01}) begin
      exp_time.push_back(PRE_T); exp_led.push_back(4'b0001); exp_alarm.push_back(1'b0);
    end
`endif
    if (m inside {2'b00, 2'b01}) begin
      exp_time.push_back(WASH_T); exp_led.push_back(4'b0010); exp_alarm.push_back(1'b0);
    end
    if (m != 2'b11) begin
      for (int i = 0; i < RINSE_N; i++) begin
        exp_time.push_back(RINSE_T); exp_led.push_back(4'b0100); exp_alarm.push_back(1'b0);
      end
    end
    if (m != 2'b01) begin
      exp_time.push_back(SPIN_T); exp_led.push_back(4'b1000); exp_alarm.push_back(1'b0);
    end
    exp_time.push_back(ALARM_T); exp_led.push_back(4'b0000); exp_alarm.push_back(1'b1);
  endfunction

  // Drop switch_en for a few cycles with spurious timer-end pulses; nothing may move.
  task automatic do_pause(input int t, input logic [3:0] led);
    int n;
    n = $urandom_range(1, 4);
    switch_en = 1'b0;
    for (int i = 0; i < n; i++) begin
      count_end_flag = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      step();
      check_output("pause.start", 32'(count_start_flag), 32'd1);
      check_output("pause.led", 32'(phase_led), 32'(led));
      check_output("pause.sum", sum_count, 32'(t));
    end
    count_end_flag = 1'b0;
    switch_en = 1'b1;
  endtask

  // Run one program from a fresh start edge. abort_from_end > 0 powers off on
  // entry to that phase (counted from the end of the list).
  task automatic apply_stimulus(input logic [1:0] m, input int abort_from_end,
                                input bit force_pause);
    int  wait_cnt;
    int  pause_at;
    bit  arm_test;
    build_program(m);
    mode = m;
    switch_en = 1'b0;
    step();
    switch_en = 1'b1;
    step();
    mode = 2'($urandom_range(0, 3));
    for (int p = 0; p < exp_time.size(); p++) begin
      check_output("gap.start", 32'(count_start_flag), 32'd0);
      check_output("gap.busy", 32'(busy), 32'd1);
      check_output("gap.led", 32'(phase_led), 32'(exp_led[p]));
      wait_cnt = 0;
      step();
      while (count_start_flag !== 1'b1 && wait_cnt < 20) begin
        step();
        wait_cnt++;
      end
      if (wait_cnt >= 20) begin
        check_output("phase_entry_timeout", 32'(wait_cnt), 32'd0);
        return;
      end
      if (!exp_alarm[p]) check_output("gap.length", 32'(wait_cnt), 32'd0);
      check_output("phase.sum", sum_count, 32'(exp_time[p]));
      check_output("phase.led", 32'(phase_led), 32'(exp_led[p]));
      check_output("phase.alarm", 32'(alarm), 32'(exp_alarm[p]));
      check_output("phase.busy", 32'(busy), 32'd1);
      if (abort_from_end > 0 && p == exp_time.size() - abort_from_end) begin
        switch_power = 1'b0;
        step();
        check_idle("power_off", 1'b1);
        return;
      end
      arm_test = 1'($urandom_range(0, 1));
      pause_at = (force_pause && p == 0) || ($urandom_range(0, 3) == 0)
                 ? $urandom_range(0, exp_time[p] - 2) : -1;
      for (int c = 0; c < exp_time[p] - 1; c++) begin
        count_end_flag = (c == 0) && arm_test;
        step();
        count_end_flag = 1'b0;
        check_output("phase.hold", 32'(count_start_flag), 32'd1);
        if (c == pause_at) do_pause(exp_time[p], exp_led[p]);
      end
      count_end_flag = 1'b1;
      step();
      count_end_flag = 1'b0;
      if (exp_alarm[p]) check_idle("end_of_cycle", 1'b0);
    end
    step();
    check_output("stay_idle.busy", 32'(busy), 32'd0);
  endtask

  // Directed sequence with randomized timer/pause behaviour inside each program.
  initial begin
    rst_n = 1'b0;
    switch_power = 1'b1;
    switch_en = 1'b1;
    mode = 2'b00;
    count_end_flag = 1'b0;
    repeat (3) step();
    check_idle("reset", 1'b1);
    rst_n = 1'b1;
    repeat (3) step();
    check_idle("no_edge_after_reset", 1'b1);

    apply_stimulus(2'b00, 0, 1'b0);
    apply_stimulus(2'b11, 0, 1'b0);
    apply_stimulus(2'b01, 0, 1'b1);
    apply_stimulus(2'b00, 3, 1'b0);
    switch_power = 1'b1;
    repeat (2) step();
    check_idle("no_restart_without_edge", 1'b1);
    apply_stimulus(2'b00, 0, 1'b0);
    for (int i = 0; i < 6; i++) apply_stimulus(2'($urandom_range(0, 3)), 0, 1'b0);

    switch_en = 1'b0;
    mode = 2'b10;
    step();
    switch_en = 1'b1;
    step();
    step();
    check_output("pre_async_reset.start", 32'(count_start_flag), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_idle("async_reset", 1'b1);
    step();
    rst_n = 1'b1;
    step();
    check_idle("after_async_reset", 1'b1);

    $display("[TB] Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard stop in case a wait ever escapes its bound.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
